axis_fifo: RTL and testbench
============================

Name: axis_fifo

Overview:
- Parametrised successor to the team's synchronous FIFO, for streaming sample and coefficient paths of the LPC encoder.
- Adds an AXI-Stream valid/ready handshake on both sides, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty watermarks, and a synchronous flush.
- Sits between the AXI front end and the encoder core; the core uses the watermarks to throttle.

Parameters:
- DATA_WIDTH, 16, payload width in bits (>=1).
- DEPTH, 128, number of entries; power of two, >=4.
- AF_THRESH, DEPTH-4, ALMOST_FULL asserts when LEVEL >= AF_THRESH (1..DEPTH).
- AE_THRESH, 4, ALMOST_EMPTY asserts when LEVEL <= AE_THRESH (0..DEPTH-1).

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of contents, one-cycle pulse or level.
- S_TVALID  in  1  upstream data valid.
- S_TREADY  out  1  FIFO can accept.
- S_TDATA  in  DATA_WIDTH  upstream payload.
- M_TVALID  out  1  head entry valid.
- M_TREADY  in  1  downstream accepts head.
- M_TDATA  out  DATA_WIDTH  head entry (fall-through).
- LEVEL  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ALMOST_FULL  out  1  watermark flag.
- ALMOST_EMPTY  out  1  watermark flag.

Behaviour:
- Reset is ARESET_N, asynchronous, active-low; clock is ACLK.
- Reset values: pointers 0, LEVEL 0, S_TREADY 1, M_TVALID 0, ALMOST_FULL 0, ALMOST_EMPTY 1, M_TDATA 0. Storage contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits. The MSB is the wrap flag; full means the low bits are equal and the MSBs differ. Pointers wrap naturally with no compare-to-max logic.
- Push: S_TVALID & S_TREADY at a rising edge writes S_TDATA to mem[wr_ptr] and increments wr_ptr.
- Pop: M_TVALID & M_TREADY at a rising edge increments rd_ptr.
- S_TREADY = ~full. M_TVALID = ~empty. Both derive from registered pointers and have no combinational path from S_TVALID or M_TREADY.
- M_TDATA = mem[rd_ptr[ADDR_W-1:0]], an asynchronous read. Latency: a word pushed into an empty FIFO at edge N appears on M_TDATA/M_TVALID immediately after edge N.
- LEVEL is a registered counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- ALMOST_FULL and ALMOST_EMPTY are compared from LEVEL_next and registered, so they are coherent with LEVEL in the same cycle.
- Push and pop in the same cycle:
  - Legal whenever not empty and not full; LEVEL is unchanged.
  - When full, no push can occur (S_TREADY=0); a pop alone makes S_TREADY=1 next cycle.
  - When empty, no pop can occur; a push alone makes M_TVALID=1 next cycle.
- Backpressure: M_TDATA stays stable while M_TVALID & ~M_TREADY. S_TVALID with S_TREADY=0 is legal stalling, not an error.
- FLUSH has priority over push and pop that cycle. At the next edge: pointers 0, LEVEL 0, flags at their reset values. Any push or pop in that cycle is discarded.
- Reset mid-transfer: all state clears immediately and asynchronously; in-flight data is lost.
- Thresholds out of range are a parameter error (elaboration assertion).

Optional Feature:
- Macro: AXIS_FIFO_TLAST_EN.
- Defined:
  - Adds ports S_TLAST (in, 1) and M_TLAST (out, 1); TLAST is stored alongside the data in each entry.
  - Adds PKT_CNT (out, $clog2(DEPTH)+1): the count of complete packets held. It increments on a push with S_TLAST=1 and decrements on a pop with M_TLAST=1; simultaneous events cancel. FLUSH and reset clear it to 0.
- Undefined: none of these ports exist; storage is DATA_WIDTH bits wide.

Decomposition:
- Package axis_fifo_pkg:
  - localparam function for the pointer width ($clog2(DEPTH)+1).
  - Entry-width constant: DATA_WIDTH, +1 with TLAST.
  - Typedef for the pointer/level type.
- Sub-module axis_fifo_ram: DEPTH x entry-width array with synchronous write port and asynchronous read port. No reset, for inference as distributed RAM.
- Top-level axis_fifo holds pointers, level, flags and handshake.

Test Plan:
- DEPTH=8, AF=6, AE=2; after reset:
  - Push 8 words 0x0001..0x0008 with M_TREADY=0 -> LEVEL counts to 8. ALMOST_EMPTY drops when LEVEL=3; ALMOST_FULL rises when LEVEL=6. S_TREADY=0 after the 8th push; a 9th S_TVALID is stalled and not stored.
- Full FIFO, M_TREADY=1 for 8 cycles -> M_TDATA sequence 0x0001..0x0008 in order. M_TVALID falls after the 8th pop; LEVEL=0.
- Continuous push+pop at level 4 for 20 cycles, crossing pointer wrap twice -> LEVEL stays 4, no data loss, and the output sequence equals the input sequence.
- Single push of 0xBEEF into an empty FIFO at edge N -> M_TVALID=1 and M_TDATA=0xBEEF right after edge N.
- Level 5, FLUSH pulsed together with S_TVALID=1 and M_TREADY=1 -> next cycle LEVEL=0, M_TVALID=0, S_TREADY=1, ALMOST_EMPTY=1.
- With AXIS_FIFO_TLAST_EN: push 3 packets of lengths 2/1/3 -> PKT_CNT=3. Pop 3 words -> PKT_CNT=1, and M_TLAST was high on the 2nd and 3rd pops. ARESET_N low mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared sizing helpers for axis_fifo (TLAST width set by AXIS_FIFO_TLAST_EN)
package axis_fifo_pkg;

`ifdef AXIS_FIFO_TLAST_EN
    localparam int TLAST_BITS = 1;
`else
    localparam int TLAST_BITS = 0;
`endif

    // Pointer/level width: address bits plus one wrap flag, so LEVEL can reach DEPTH.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Stored entry width: payload plus the packet-end marker when enabled.
    function automatic int entry_width(input int data_width);
        return data_width + TLAST_BITS;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// rtl/axis_fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module axis_fifo_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents deliberately left unreset so this maps onto distributed RAM.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port is combinational so the head entry falls through without a cycle of latency.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FWFT FIFO with level, watermarks and flush; optional TLAST/PKT_CNT via AXIS_FIFO_TLAST_EN
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    localparam int PTR_W     = ptr_width(DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESET_N,
    input  logic                  FLUSH,
    input  logic                  S_TVALID,
    output logic                  S_TREADY,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
`ifdef AXIS_FIFO_TLAST_EN
    input  logic                  S_TLAST,
    output logic                  M_TLAST,
    output logic [PTR_W-1:0]      PKT_CNT,
`endif
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic [PTR_W-1:0]      LEVEL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY
);

    localparam int ADDR_W  = PTR_W - 1;
    localparam int ENTRY_W = entry_width(DATA_WIDTH);

    typedef logic [PTR_W-1:0] ptr_t;

    // Bad watermarks or geometry are rejected while elaborating.
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("axis_fifo: AF_THRESH must be within 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("axis_fifo: AE_THRESH must be within 0..DEPTH-1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 4");
    end

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t level_next;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake state comes only from registered pointers, so there is no valid-to-ready path.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        S_TREADY = ~full;
        M_TVALID = ~empty;
        push     = S_TVALID & ~full;
        pop      = M_TREADY & ~empty;
    end

    // Occupancy after this edge, used so the watermarks line up with LEVEL.
    always_comb begin
        level_next = LEVEL;
        if (push && !pop) begin
            level_next = LEVEL + ptr_t'(1);
        end else if (pop && !push) begin
            level_next = LEVEL - ptr_t'(1);
        end
    end

    // Pointers, level and watermarks; flush wins over any push or pop in the same cycle.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            LEVEL        <= '0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else if (FLUSH) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            LEVEL        <= '0;
            ALMOST_FULL  <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            LEVEL        <= level_next;
            ALMOST_FULL  <= (level_next >= ptr_t'(AF_THRESH));
            ALMOST_EMPTY <= (level_next <= ptr_t'(AE_THRESH));
        end
    end

`ifdef AXIS_FIFO_TLAST_EN
    // Packet-end marker rides in the top bit of each stored entry.
    always_comb begin
        wr_entry = {S_TLAST, S_TDATA};
        M_TLAST  = ~empty & rd_entry[DATA_WIDTH];
    end

    // Complete-packet count: +1 on a pushed TLAST, -1 on a popped TLAST, both cancel.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            PKT_CNT <= '0;
        end else if (FLUSH) begin
            PKT_CNT <= '0;
        end else if ((push && S_TLAST) && !(pop && M_TLAST)) begin
            PKT_CNT <= PKT_CNT + ptr_t'(1);
        end else if (!(push && S_TLAST) && (pop && M_TLAST)) begin
            PKT_CNT <= PKT_CNT - ptr_t'(1);
        end
    end
`else
    // Storage carries only the payload.
    always_comb begin
        wr_entry = S_TDATA;
    end
`endif

    // Head entry falls through; forced to zero while empty so it never shows stale RAM.
    always_comb begin
        M_TDATA = empty ? '0 : rd_entry[DATA_WIDTH-1:0];
    end

    axis_fifo_ram #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .ACLK    (ACLK),
        .wr_en   (push & ~FLUSH),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - directed self-checking bench for axis_fifo (DEPTH=8, AF=6, AE=2)
module tb_axis_fifo;

    localparam int DW = 16;
    localparam int PW = 4;

    logic          ACLK = 1'b0;
    logic          ARESET_N = 1'b0;
    logic          FLUSH = 1'b0;
    logic          S_TVALID = 1'b0;
    logic          S_TREADY;
    logic [DW-1:0] S_TDATA = '0;
    logic          M_TVALID;
    logic          M_TREADY = 1'b0;
    logic [DW-1:0] M_TDATA;
    logic [PW-1:0] LEVEL;
    logic          ALMOST_FULL;
    logic          ALMOST_EMPTY;
`ifdef AXIS_FIFO_TLAST_EN
    logic          S_TLAST = 1'b0;
    logic          M_TLAST;
    logic [PW-1:0] PKT_CNT;
`endif

    int tests = 0;
    int fails = 0;

    always #5 ACLK = ~ACLK;

    axis_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (8),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .ACLK         (ACLK),
        .ARESET_N     (ARESET_N),
        .FLUSH        (FLUSH),
        .S_TVALID     (S_TVALID),
        .S_TREADY     (S_TREADY),
        .S_TDATA      (S_TDATA),
`ifdef AXIS_FIFO_TLAST_EN
        .S_TLAST      (S_TLAST),
        .M_TLAST      (M_TLAST),
        .PKT_CNT      (PKT_CNT),
`endif
        .M_TVALID     (M_TVALID),
        .M_TREADY     (M_TREADY),
        .M_TDATA      (M_TDATA),
        .LEVEL        (LEVEL),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESET_N = 1'b0;
        step();
        step();
        tests++;
        if ({S_TREADY, M_TVALID, ALMOST_FULL, ALMOST_EMPTY} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_flags got %b want 1001", {S_TREADY, M_TVALID, ALMOST_FULL, ALMOST_EMPTY});
        end
        tests++;
        if (LEVEL !== 4'd0 || M_TDATA !== 16'h0) begin
            fails++;
            $display("FAIL reset_level_data got level=%0d data=%h want 0/0000", LEVEL, M_TDATA);
        end
        ARESET_N = 1'b1;
        step();
    endtask

    task automatic test_fill();
        M_TREADY = 1'b0;
        S_TVALID = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            S_TDATA = 16'(i);
            step();
            tests++;
            if (LEVEL !== 4'(i)) begin
                fails++;
                $display("FAIL fill_level i=%0d got %0d want %0d", i, LEVEL, i);
            end
            tests++;
            if (ALMOST_EMPTY !== (i <= 2) || ALMOST_FULL !== (i >= 6)) begin
                fails++;
                $display("FAIL fill_flags i=%0d got ae=%b af=%b want ae=%b af=%b", i, ALMOST_EMPTY, ALMOST_FULL, (i <= 2), (i >= 6));
            end
            tests++;
            if (S_TREADY !== (i < 8) || M_TVALID !== 1'b1 || M_TDATA !== 16'h0001) begin
                fails++;
                $display("FAIL fill_hs i=%0d got rdy=%b vld=%b data=%h want rdy=%b vld=1 data=0001", i, S_TREADY, M_TVALID, M_TDATA, (i < 8));
            end
        end
        S_TDATA = 16'h0099;
        step();
        S_TVALID = 1'b0;
        tests++;
        if (LEVEL !== 4'd8 || S_TREADY !== 1'b0) begin
            fails++;
            $display("FAIL fill_stall got level=%0d rdy=%b want 8/0", LEVEL, S_TREADY);
        end
    endtask

    task automatic test_drain();
        M_TREADY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tests++;
            if (M_TVALID !== 1'b1 || M_TDATA !== 16'(i)) begin
                fails++;
                $display("FAIL drain_data i=%0d got vld=%b data=%h want 1/%h", i, M_TVALID, M_TDATA, 16'(i));
            end
            step();
            tests++;
            if (LEVEL !== 4'(8 - i) || S_TREADY !== 1'b1) begin
                fails++;
                $display("FAIL drain_level i=%0d got level=%0d rdy=%b want %0d/1", i, LEVEL, S_TREADY, 8 - i);
            end
        end
        M_TREADY = 1'b0;
        tests++;
        if (M_TVALID !== 1'b0 || ALMOST_EMPTY !== 1'b1 || ALMOST_FULL !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty got vld=%b ae=%b af=%b want 0/1/0", M_TVALID, ALMOST_EMPTY, ALMOST_FULL);
        end
    endtask

    task automatic test_back_to_back();
        S_TVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            S_TDATA = 16'(16'h0100 + i);
            step();
        end
        M_TREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            S_TDATA = 16'(16'h0104 + i);
            tests++;
            if (M_TDATA !== 16'(16'h0100 + i)) begin
                fails++;
                $display("FAIL b2b_data i=%0d got %h want %h", i, M_TDATA, 16'(16'h0100 + i));
            end
            step();
            tests++;
            if (LEVEL !== 4'd4 || ALMOST_EMPTY !== 1'b0 || ALMOST_FULL !== 1'b0) begin
                fails++;
                $display("FAIL b2b_level i=%0d got level=%0d ae=%b af=%b want 4/0/0", i, LEVEL, ALMOST_EMPTY, ALMOST_FULL);
            end
        end
        S_TVALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (M_TDATA !== 16'(16'h0114 + k)) begin
                fails++;
                $display("FAIL b2b_tail k=%0d got %h want %h", k, M_TDATA, 16'(16'h0114 + k));
            end
            step();
        end
        M_TREADY = 1'b0;
        tests++;
        if (LEVEL !== 4'd0 || M_TVALID !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty got level=%0d vld=%b want 0/0", LEVEL, M_TVALID);
        end
    endtask

    task automatic test_fall_through();
        S_TDATA  = 16'hBEEF;
        S_TVALID = 1'b1;
        step();
        S_TVALID = 1'b0;
        tests++;
        if (M_TVALID !== 1'b1 || M_TDATA !== 16'hBEEF || LEVEL !== 4'd1) begin
            fails++;
            $display("FAIL fwft got vld=%b data=%h level=%0d want 1/beef/1", M_TVALID, M_TDATA, LEVEL);
        end
        step();
        step();
        tests++;
        if (M_TDATA !== 16'hBEEF || LEVEL !== 4'd1) begin
            fails++;
            $display("FAIL backpressure_hold got data=%h level=%0d want beef/1", M_TDATA, LEVEL);
        end
        M_TREADY = 1'b1;
        step();
        M_TREADY = 1'b0;
        tests++;
        if (M_TVALID !== 1'b0 || LEVEL !== 4'd0) begin
            fails++;
            $display("FAIL fwft_pop got vld=%b level=%0d want 0/0", M_TVALID, LEVEL);
        end
    endtask

    task automatic test_flush();
        S_TVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            S_TDATA = 16'(16'h0200 + i);
            step();
        end
        tests++;
        if (LEVEL !== 4'd5) begin
            fails++;
            $display("FAIL flush_pre got level=%0d want 5", LEVEL);
        end
        FLUSH    = 1'b1;
        M_TREADY = 1'b1;
        S_TDATA  = 16'h0AAA;
        step();
        FLUSH    = 1'b0;
        S_TVALID = 1'b0;
        M_TREADY = 1'b0;
        tests++;
        if (LEVEL !== 4'd0 || M_TVALID !== 1'b0 || S_TREADY !== 1'b1 || ALMOST_EMPTY !== 1'b1 || ALMOST_FULL !== 1'b0) begin
            fails++;
            $display("FAIL flush_state got level=%0d vld=%b rdy=%b ae=%b af=%b want 0/0/1/1/0", LEVEL, M_TVALID, S_TREADY, ALMOST_EMPTY, ALMOST_FULL);
        end
        S_TDATA  = 16'h0055;
        S_TVALID = 1'b1;
        step();
        S_TVALID = 1'b0;
        tests++;
        if (M_TDATA !== 16'h0055 || LEVEL !== 4'd1) begin
            fails++;
            $display("FAIL flush_after got data=%h level=%0d want 0055/1", M_TDATA, LEVEL);
        end
        M_TREADY = 1'b1;
        step();
        M_TREADY = 1'b0;
    endtask

`ifdef AXIS_FIFO_TLAST_EN
    task automatic test_tlast();
        logic [5:0] lasts;
        logic [2:0] seen;
        lasts = 6'b100110;
        S_TVALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            S_TDATA = 16'(16'h0300 + i);
            S_TLAST = lasts[i];
            step();
        end
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        tests++;
        if (PKT_CNT !== 4'd3 || LEVEL !== 4'd6) begin
            fails++;
            $display("FAIL tlast_pkts got pkt=%0d level=%0d want 3/6", PKT_CNT, LEVEL);
        end
        M_TREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen[i] = M_TLAST;
            step();
        end
        M_TREADY = 1'b0;
        tests++;
        if (seen !== 3'b110) begin
            fails++;
            $display("FAIL tlast_seen got %b want 110", seen);
        end
        tests++;
        if (PKT_CNT !== 4'd1 || LEVEL !== 4'd3) begin
            fails++;
            $display("FAIL tlast_after_pop got pkt=%0d level=%0d want 1/3", PKT_CNT, LEVEL);
        end
    endtask
`endif

    task automatic test_async_reset();
        S_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            S_TDATA = 16'(16'h0400 + i);
`ifdef AXIS_FIFO_TLAST_EN
            S_TLAST = 1'b1;
`endif
            step();
        end
        tests++;
        if (M_TVALID !== 1'b1 || LEVEL === 4'd0) begin
            fails++;
            $display("FAIL areset_pre got vld=%b level=%0d want 1/nonzero", M_TVALID, LEVEL);
        end
        #2;
        ARESET_N = 1'b0;
        #1;
        tests++;
        if (LEVEL !== 4'd0 || M_TVALID !== 1'b0 || S_TREADY !== 1'b1 || ALMOST_EMPTY !== 1'b1 || ALMOST_FULL !== 1'b0 || M_TDATA !== 16'h0) begin
            fails++;
            $display("FAIL areset_async got level=%0d vld=%b rdy=%b ae=%b af=%b data=%h want 0/0/1/1/0/0000", LEVEL, M_TVALID, S_TREADY, ALMOST_EMPTY, ALMOST_FULL, M_TDATA);
        end
`ifdef AXIS_FIFO_TLAST_EN
        tests++;
        if (PKT_CNT !== 4'd0 || M_TLAST !== 1'b0) begin
            fails++;
            $display("FAIL areset_pkt got pkt=%0d last=%b want 0/0", PKT_CNT, M_TLAST);
        end
        S_TLAST = 1'b0;
`endif
        S_TVALID = 1'b0;
        step();
        ARESET_N = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_fall_through();
        test_flush();
`ifdef AXIS_FIFO_TLAST_EN
        test_tlast();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
